// File: rtl/serdes_rx_aligner_if.sv
// Serial-bit-in / aligned-word-out bundle for serdes_rx_aligner.
// master: serial front end that drives bits and observes words; slave: the aligner.
interface serdes_rx_aligner_if #(
  parameter int DATA_W = 16
);
  logic              bit_in;
  logic              bit_valid;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_is_comma;
  logic              aligned;
  logic              lock_lost;
  logic [7:0]        comma_err_cnt;

  modport master (
    output bit_in,
    output bit_valid,
    input  rx_data,
    input  rx_valid,
    input  rx_is_comma,
    input  aligned,
    input  lock_lost,
    input  comma_err_cnt
  );

  modport slave (
    input  bit_in,
    input  bit_valid,
    output rx_data,
    output rx_valid,
    output rx_is_comma,
    output aligned,
    output lock_lost,
    output comma_err_cnt
  );
endinterface

// File: rtl/serdes_rx_aligner.sv
// Deserializes a qualified serial bit stream into DATA_W-bit words, finds the word
// boundary from a comma pattern at any bit offset, confirms lock and tracks its loss.
module serdes_rx_aligner #(
  parameter int                DATA_W     = 16,
  parameter logic [DATA_W-1:0] COMMA      = 16'h50BC,
  parameter int                LOCK_CNT   = 4,
  parameter int                UNLOCK_CNT = 3,
  parameter bit                LSB_FIRST  = 1'b1
) (
  input logic                clk,
  input logic                rst,
  serdes_rx_aligner_if.slave rx
);

  localparam int CNT_W   = $clog2(DATA_W);
  localparam int MATCH_W = $clog2(LOCK_CNT + 1);
  localparam int MISS_W  = $clog2(UNLOCK_CNT + 1);

  localparam logic [CNT_W-1:0]   WORD_LAST   = CNT_W'(DATA_W - 1);
  localparam logic [MATCH_W-1:0] MATCH_LAST  = MATCH_W'(LOCK_CNT - 1);
  localparam logic [MATCH_W-1:0] MATCH_ONE   = MATCH_W'(1);
  localparam logic [MISS_W-1:0]  MISS_LAST   = MISS_W'(UNLOCK_CNT - 1);
  localparam bit                 DIRECT_LOCK = (LOCK_CNT == 1);

  typedef enum logic [1:0] {
    ST_HUNT    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   sr_reg;
  logic [DATA_W-1:0]   sr_shift;
  logic [CNT_W-1:0]    fill_reg, fill_next;
  logic [CNT_W-1:0]    bcnt_reg, bcnt_next;
  logic [MATCH_W-1:0]  match_reg, match_next;
  logic [MISS_W-1:0]   miss_reg, miss_next;
  logic [7:0]          err_reg, err_next;

  logic [DATA_W-1:0]   rx_data_reg;
  logic                rx_valid_reg;
  logic                rx_is_comma_reg;
  logic                lock_lost_reg;

  logic                boundary;
  logic                word_is_comma;
  logic                comma_hit;
  logic                emit;
  logic                lost;

  // Candidate word including the bit on the input this cycle.
  genvar gi;
  generate
    if (LSB_FIRST) begin : g_lsb_first
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
        if (gi == DATA_W - 1) begin : g_top
          assign sr_shift[gi] = rx.bit_in;
        end else begin : g_mid
          assign sr_shift[gi] = sr_reg[gi+1];
        end
      end
    end else begin : g_msb_first
      for (gi = 0; gi < DATA_W; gi++) begin : g_bit
        if (gi == 0) begin : g_bottom
          assign sr_shift[gi] = rx.bit_in;
        end else begin : g_mid
          assign sr_shift[gi] = sr_reg[gi-1];
        end
      end
    end
  endgenerate

  // fill saturates at DATA_W-1, so equality means a full word is available.
  assign word_is_comma = (sr_shift == COMMA);
  assign boundary      = rx.bit_valid && (bcnt_reg == WORD_LAST);
  assign comma_hit     = rx.bit_valid && (fill_reg == WORD_LAST) && word_is_comma;

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_reg   <= '0;
      fill_reg <= '0;
    end else if (rx.bit_valid) begin
      sr_reg   <= sr_shift;
      fill_reg <= fill_next;
    end
  end

  assign fill_next = (fill_reg == WORD_LAST) ? fill_reg : fill_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_HUNT;
      bcnt_reg  <= '0;
      match_reg <= '0;
      miss_reg  <= '0;
      err_reg   <= '0;
    end else begin
      state_reg <= state_next;
      bcnt_reg  <= bcnt_next;
      match_reg <= match_next;
      miss_reg  <= miss_next;
      err_reg   <= err_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    match_next = match_reg;
    miss_next  = miss_reg;
    err_next   = err_reg;
    emit       = 1'b0;
    lost       = 1'b0;
    bcnt_next  = bcnt_reg;
    if (rx.bit_valid) begin
      bcnt_next = boundary ? '0 : bcnt_reg + 1'b1;
    end

    case (state_reg)
      ST_HUNT: begin
        if (comma_hit) begin
          bcnt_next  = '0;
          match_next = MATCH_ONE;
          miss_next  = '0;
          emit       = 1'b1;
          state_next = DIRECT_LOCK ? ST_LOCKED : ST_CONFIRM;
        end
      end

      ST_CONFIRM: begin
        if (boundary) begin
          emit = 1'b1;
          if (word_is_comma) begin
            if (match_reg == MATCH_LAST) begin
              state_next = ST_LOCKED;
              miss_next  = '0;
            end else begin
              match_next = match_reg + 1'b1;
            end
          end
        end else if (comma_hit) begin
          // Comma at a new offset: restart confirmation on that boundary.
          bcnt_next  = '0;
          match_next = MATCH_ONE;
          emit       = 1'b1;
        end
      end

      ST_LOCKED: begin
        if (boundary) begin
          emit = 1'b1;
          if (word_is_comma) begin
            miss_next = '0;
          end
        end else if (comma_hit) begin
          // Boundary is kept; only repeated misplaced commas drop the lock.
          if (err_reg != 8'hFF) begin
            err_next = err_reg + 1'b1;
          end
          if (miss_reg == MISS_LAST) begin
            state_next = ST_HUNT;
            lost       = 1'b1;
            miss_next  = '0;
            match_next = '0;
          end else begin
            miss_next = miss_reg + 1'b1;
          end
        end
      end

      default: begin
        state_next = ST_HUNT;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data_reg     <= '0;
      rx_valid_reg    <= 1'b0;
      rx_is_comma_reg <= 1'b0;
      lock_lost_reg   <= 1'b0;
    end else begin
      rx_valid_reg    <= emit;
      rx_is_comma_reg <= emit && word_is_comma;
      lock_lost_reg   <= lost;
      if (emit) begin
        rx_data_reg <= sr_shift;
      end
    end
  end

  assign rx.rx_data       = rx_data_reg;
  assign rx.rx_valid      = rx_valid_reg;
  assign rx.rx_is_comma   = rx_is_comma_reg;
  assign rx.aligned       = (state_reg == ST_LOCKED);
  assign rx.lock_lost     = lock_lost_reg;
  assign rx.comma_err_cnt = err_reg;

endmodule

// File: tb/tb_serdes_rx_aligner.sv
// Directed, table-driven bench for serdes_rx_aligner: LSB-first and MSB-first instances
// fed the same word stream, strobes/events logged by a monitor and compared to tables.
module tb_serdes_rx_aligner;

  localparam int          DW = 16;
  localparam logic [15:0] CM = 16'h50BC;
  localparam logic [15:0] DT = 16'h1234;

  typedef struct {
    logic [15:0] data;
    logic        comma;
    logic        aligned;
    int          bitno;
  } strobe_t;

  typedef struct {
    logic [7:0] err;
    logic       aligned;
    int         bitno;
  } ev_t;

  logic    clk = 1'b0;
  logic    rst = 1'b1;
  int      n_total = 0;
  int      n_bad = 0;
  int      vbits = 0;
  logic [7:0] err_prev = 8'd0;

  strobe_t a_log[$];
  strobe_t b_log[$];
  ev_t     err_log[$];
  ev_t     lost_log[$];
  strobe_t exp_tab[8];
  ev_t     err_exp[$];
  ev_t     lost_exp[$];
  ev_t     none_exp[$];

  always #5 clk = ~clk;

  serdes_rx_aligner_if #(.DATA_W(DW)) a_if ();
  serdes_rx_aligner_if #(.DATA_W(DW)) b_if ();

  serdes_rx_aligner #(
    .DATA_W(DW), .COMMA(CM), .LOCK_CNT(4), .UNLOCK_CNT(3), .LSB_FIRST(1'b1)
  ) dut_a (
    .clk(clk), .rst(rst), .rx(a_if)
  );

  serdes_rx_aligner #(
    .DATA_W(DW), .COMMA(CM), .LOCK_CNT(4), .UNLOCK_CNT(3), .LSB_FIRST(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .rx(b_if)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] pack_a();
    return {4'b0, a_if.comma_err_cnt, a_if.lock_lost, a_if.aligned,
            a_if.rx_is_comma, a_if.rx_valid, a_if.rx_data};
  endfunction

  function automatic logic [31:0] pack_b();
    return {4'b0, b_if.comma_err_cnt, b_if.lock_lost, b_if.aligned,
            b_if.rx_is_comma, b_if.rx_valid, b_if.rx_data};
  endfunction

  // Monitor: counts valid bits at each edge, then logs outputs 1 time unit later.
  always @(posedge clk) begin : monitor
    logic    bv;
    strobe_t s;
    ev_t     e;
    bv = a_if.bit_valid;
    if (rst) vbits = 0;
    else if (bv) vbits++;
    #1;
    if (rst) begin
      err_prev = 8'd0;
    end else begin
      if (a_if.rx_valid) begin
        s.data = a_if.rx_data; s.comma = a_if.rx_is_comma;
        s.aligned = a_if.aligned; s.bitno = vbits;
        a_log.push_back(s);
        check("strobe_after_valid_bit_a", 32'(bv), 32'd1);
      end
      if (b_if.rx_valid) begin
        s.data = b_if.rx_data; s.comma = b_if.rx_is_comma;
        s.aligned = b_if.aligned; s.bitno = vbits;
        b_log.push_back(s);
      end
      if (a_if.comma_err_cnt != err_prev) begin
        e.err = a_if.comma_err_cnt; e.aligned = a_if.aligned; e.bitno = vbits;
        err_log.push_back(e);
        err_prev = a_if.comma_err_cnt;
      end
      if (a_if.lock_lost) begin
        e.err = a_if.comma_err_cnt; e.aligned = a_if.aligned; e.bitno = vbits;
        lost_log.push_back(e);
      end
    end
  end

  task automatic send_bit(input logic ba, input logic bb, input int gap_pct);
    while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) begin
      @(negedge clk);
      a_if.bit_valid = 1'b0; b_if.bit_valid = 1'b0;
      a_if.bit_in = 1'($urandom); b_if.bit_in = 1'($urandom);
    end
    @(negedge clk);
    a_if.bit_valid = 1'b1; b_if.bit_valid = 1'b1;
    a_if.bit_in = ba; b_if.bit_in = bb;
  endtask

  // a_if gets the word LSB first, b_if MSB first; skip drops the first bits sent.
  task automatic send_word(input logic [15:0] w, input int skip, input int gap_pct);
    for (int i = skip; i < 16; i++) send_bit(w[i], w[15-i], gap_pct);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      a_if.bit_valid = 1'b0; b_if.bit_valid = 1'b0;
    end
  endtask

  task automatic clear_logs();
    a_log.delete(); b_log.delete(); err_log.delete(); lost_log.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; a_if.bit_valid = 1'b0; b_if.bit_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic run_acq(input int gap_pct);
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, gap_pct);
    send_word(CM, 0, gap_pct);
    send_word(DT, 0, gap_pct);
    repeat (3) send_word(CM, 0, gap_pct);
  endtask

  task automatic run_slip(input int gap_pct);
    send_word(CM, 1, gap_pct);
    repeat (3) send_word(CM, 0, gap_pct);
  endtask

  task automatic cmp_strobes(input string tag, input strobe_t got[$], input int n, input bit exact);
    if (exact) check({tag, ".count"}, 32'(got.size()), 32'(n));
    else       check({tag, ".count_min"}, 32'(got.size() >= n), 32'd1);
    for (int i = 0; i < n && i < got.size(); i++) begin
      check($sformatf("%s[%0d].data", tag, i), 32'(got[i].data), 32'(exp_tab[i].data));
      check($sformatf("%s[%0d].comma", tag, i), 32'(got[i].comma), 32'(exp_tab[i].comma));
      check($sformatf("%s[%0d].aligned", tag, i), 32'(got[i].aligned), 32'(exp_tab[i].aligned));
      check($sformatf("%s[%0d].bitno", tag, i), 32'(got[i].bitno), 32'(exp_tab[i].bitno));
    end
  endtask

  task automatic cmp_events(input string tag, input ev_t got[$], input ev_t exp[$]);
    check({tag, ".count"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < got.size(); i++) begin
      check($sformatf("%s[%0d].err", tag, i), 32'(got[i].err), 32'(exp[i].err));
      check($sformatf("%s[%0d].aligned", tag, i), 32'(got[i].aligned), 32'(exp[i].aligned));
      check($sformatf("%s[%0d].bitno", tag, i), 32'(got[i].bitno), 32'(exp[i].bitno));
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    // Lock run followed by a one-bit slip; bit numbers count valid bits since reset.
    exp_tab[0] = '{16'h50BC, 1'b1, 1'b0, 21};
    exp_tab[1] = '{16'h1234, 1'b0, 1'b0, 37};
    exp_tab[2] = '{16'h50BC, 1'b1, 1'b0, 53};
    exp_tab[3] = '{16'h50BC, 1'b1, 1'b0, 69};
    exp_tab[4] = '{16'h50BC, 1'b1, 1'b1, 85};
    exp_tab[5] = '{16'h285E, 1'b0, 1'b1, 101};
    exp_tab[6] = '{16'h285E, 1'b0, 1'b1, 117};
    exp_tab[7] = '{16'h50BC, 1'b1, 1'b0, 148};
    err_exp.push_back('{8'd1, 1'b1, 100});
    err_exp.push_back('{8'd2, 1'b1, 116});
    err_exp.push_back('{8'd3, 1'b0, 132});
    lost_exp.push_back('{8'd3, 1'b0, 132});

    a_if.bit_in = 1'b0; a_if.bit_valid = 1'b0;
    b_if.bit_in = 1'b0; b_if.bit_valid = 1'b0;

    // Reset held with random serial input, then first cycle after release.
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_if.bit_valid = 1'($urandom); b_if.bit_valid = a_if.bit_valid;
      a_if.bit_in = 1'($urandom); b_if.bit_in = 1'($urandom);
      @(posedge clk); #1;
      check($sformatf("rst_hold_a[%0d]", i), pack_a(), 32'd0);
      check($sformatf("rst_hold_b[%0d]", i), pack_b(), 32'd0);
      @(negedge clk);
    end
    rst = 1'b0;
    a_if.bit_valid = 1'b1; b_if.bit_valid = 1'b1;
    @(posedge clk); #1;
    check("rst_release_a", pack_a(), 32'd0);
    check("rst_release_b", pack_b(), 32'd0);

    // Acquisition, MSB-first instance, then slip on the locked LSB-first instance.
    do_reset();
    run_acq(0);
    run_slip(0);
    idle(4);
    cmp_strobes("acq_slip", a_log, 8, 1'b1);
    cmp_strobes("msb_first", b_log, 5, 1'b0);
    cmp_events("slip_err", err_log, err_exp);
    cmp_events("slip_lost", lost_log, lost_exp);
    check("slip_aligned_end", 32'(a_if.aligned), 32'd0);
    check("slip_err_end", 32'(a_if.comma_err_cnt), 32'd3);

    // Same stream with bit_valid low roughly 40% of cycles.
    do_reset();
    run_acq(40);
    run_slip(40);
    idle(4);
    cmp_strobes("gapped", a_log, 8, 1'b1);
    cmp_strobes("gapped_msb", b_log, 5, 1'b0);
    cmp_events("gapped_err", err_log, err_exp);
    cmp_events("gapped_lost", lost_log, lost_exp);

    // Reset in CONFIRM after two commas, mid-word, then full re-acquisition.
    do_reset();
    for (int i = 0; i < 5; i++) send_bit(1'b0, 1'b0, 0);
    send_word(CM, 0, 0);
    send_word(DT, 0, 0);
    send_word(CM, 0, 0);
    for (int i = 0; i < 7; i++) send_bit(CM[i], CM[15-i], 0);
    @(negedge clk);
    cmp_strobes("pre_rst", a_log, 3, 1'b1);
    rst = 1'b1;
    a_if.bit_in = 1'($urandom); b_if.bit_in = 1'($urandom);
    @(posedge clk); #1;
    check("rst_mid_word_a", pack_a(), 32'd0);
    check("rst_mid_word_b", pack_b(), 32'd0);
    @(negedge clk);
    rst = 1'b0; a_if.bit_valid = 1'b0; b_if.bit_valid = 1'b0;
    clear_logs();
    run_acq(0);
    idle(4);
    cmp_strobes("reacq", a_log, 5, 1'b1);
    cmp_events("reacq_err", err_log, none_exp);
    cmp_events("reacq_lost", lost_log, none_exp);
    check("reacq_aligned_end", 32'(a_if.aligned), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
